seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 7-segment display driver.
- Watches the active-low anode enables (DISP_EN) and the active-low segment bus (SEGMENTS), and filters out transition glitches.
- Decodes each stable digit pattern back to a character code, then assembles a complete 4-digit frame.
- Used as an on-board self-check and loopback monitor, and as a bench scoreboard front-end for display logic.

---
 rtl/seg_pkg.sv | 38 +++
 rtl/seg_pattern_decode.sv | 36 +++
 rtl/seg_scan_decoder.sv | 155 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan decoder and display-side drivers.
// Segment patterns are a..g (bit 6 = a), active low; char codes are 5 bits.
package seg_pkg;

  localparam logic [4:0] CH_L     = 5'h10;
  localparam logic [4:0] CH_R     = 5'h11;
  localparam logic [4:0] CH_BLANK = 5'h12;
  localparam logic [4:0] CH_P     = 5'h13;
  localparam logic [4:0] CH_UNK   = 5'h1F;

  localparam logic [6:0] PAT_0     = 7'b0000001;
  localparam logic [6:0] PAT_1     = 7'b1001111;
  localparam logic [6:0] PAT_2     = 7'b0010010;
  localparam logic [6:0] PAT_3     = 7'b0000110;
  localparam logic [6:0] PAT_4     = 7'b1001100;
  localparam logic [6:0] PAT_5     = 7'b0100100;
  localparam logic [6:0] PAT_6     = 7'b0100000;
  localparam logic [6:0] PAT_7     = 7'b0001111;
  localparam logic [6:0] PAT_8     = 7'b0000000;
  localparam logic [6:0] PAT_9     = 7'b0000100;
  localparam logic [6:0] PAT_A     = 7'b0001000;
  localparam logic [6:0] PAT_B     = 7'b1100000;
  localparam logic [6:0] PAT_C     = 7'b0110001;
  localparam logic [6:0] PAT_D     = 7'b1000010;
  localparam logic [6:0] PAT_E     = 7'b0110000;
  localparam logic [6:0] PAT_F     = 7'b0111000;
  localparam logic [6:0] PAT_L     = 7'b1110001;
  localparam logic [6:0] PAT_R     = 7'b1111010;
  localparam logic [6:0] PAT_BLANK = 7'b1111111;
  localparam logic [6:0] PAT_P     = 7'b0011000;

  typedef enum logic [1:0] {
    StWait,
    StAccept,
    StHold
  } state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational map from an active-low a..g pattern to a 5-bit char code.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [4:0] code_o
);

  always_comb begin
    code_o = CH_UNK;
    case (pat_i)
      PAT_0:     code_o = 5'h00;
      PAT_1:     code_o = 5'h01;
      PAT_2:     code_o = 5'h02;
      PAT_3:     code_o = 5'h03;
      PAT_4:     code_o = 5'h04;
      PAT_5:     code_o = 5'h05;
      PAT_6:     code_o = 5'h06;
      PAT_7:     code_o = 5'h07;
      PAT_8:     code_o = 5'h08;
      PAT_9:     code_o = 5'h09;
      PAT_A:     code_o = 5'h0A;
      PAT_B:     code_o = 5'h0B;
      PAT_C:     code_o = 5'h0C;
      PAT_D:     code_o = 5'h0D;
      PAT_E:     code_o = 5'h0E;
      PAT_F:     code_o = 5'h0F;
      PAT_L:     code_o = CH_L;
      PAT_R:     code_o = CH_R;
      PAT_BLANK: code_o = CH_BLANK;
      PAT_P:     code_o = CH_P;
      default:   code_o = CH_UNK;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed 7-segment scan, de-glitches it and rebuilds 4-digit frames.
// Each stable {DISP_EN,SEGMENTS} interval is accepted exactly once.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  DISP_EN,
  input  logic [7:0]  SEGMENTS,
  output logic [19:0] CHARS,
  output logic [3:0]  DPS,
  output logic        FRAME_VLD,
  output logic        STALE,
  output logic        ERR
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [11:0]     in_q, prev_q, smp_q, smp_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [TW-1:0]   to_q, to_d;
  logic [3:0]      seen_q, seen_d;
  logic [3:0][4:0] slot_q, slot_d;
  logic [3:0]      sdp_q, sdp_d;
  logic [19:0]     chars_q, chars_d;
  logic [3:0]      dps_q, dps_d;
  logic            vld_q, vld_d;
  logic            err_q, err_d;
  logic            chg;
  logic [3:0]      hit;
  logic            bad_en;
  logic [4:0]      dec_code;

  seg_pattern_decode u_decode (
    .pat_i  (smp_q[7:1]),
    .code_o (dec_code)
  );

  // stab_q describes how long prev_q has held its value
  assign chg = (in_q != prev_q);

  always_comb begin
    if (chg) begin
      stab_d = SW'(1);
    end else if (stab_q == STABLE_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 1'b1;
    end
  end

  always_comb begin
    hit    = 4'b0000;
    bad_en = 1'b0;
    case (smp_q[11:8])
      4'b1110: hit = 4'b0001;
      4'b1101: hit = 4'b0010;
      4'b1011: hit = 4'b0100;
      4'b0111: hit = 4'b1000;
      4'b1111: hit = 4'b0000;
      default: bad_en = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    seen_d  = seen_q;
    slot_d  = slot_q;
    sdp_d   = sdp_q;
    chars_d = chars_q;
    dps_d   = dps_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    to_d    = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
    case (state_q)
      StWait: begin
        if (stab_q == STABLE_MAX) begin
          smp_d   = prev_q;
          state_d = StAccept;
        end
      end
      StAccept: begin
        state_d = chg ? StWait : StHold;
        err_d   = bad_en;
        if (hit != 4'b0000) begin
          to_d = '0;
          for (int i = 0; i < 4; i++) begin
            if (hit[i]) begin
              slot_d[i] = dec_code;
              sdp_d[i]  = ~smp_q[0];
            end
          end
          seen_d = seen_q | hit;
          if (seen_d == 4'b1111) begin
            chars_d = slot_d;
            dps_d   = sdp_d;
            vld_d   = 1'b1;
            seen_d  = 4'b0000;
          end
        end
      end
      StHold: begin
        if (chg) state_d = StWait;
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StWait;
      in_q    <= 12'hFFF;
      prev_q  <= 12'hFFF;
      smp_q   <= 12'hFFF;
      stab_q  <= '0;
      to_q    <= '0;
      seen_q  <= 4'b0000;
      slot_q  <= {4{CH_BLANK}};
      sdp_q   <= 4'b0000;
      chars_q <= {4{CH_BLANK}};
      dps_q   <= 4'b0000;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= {DISP_EN, SEGMENTS};
      prev_q  <= in_q;
      smp_q   <= smp_d;
      stab_q  <= stab_d;
      to_q    <= to_d;
      seen_q  <= seen_d;
      slot_q  <= slot_d;
      sdp_q   <= sdp_d;
      chars_q <= chars_d;
      dps_q   <= dps_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign CHARS     = chars_q;
  assign DPS       = dps_q;
  assign FRAME_VLD = vld_q;
  assign ERR       = err_q;
  assign STALE     = (to_q >= TO_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench: expected frames are queued at stimulus time, a monitor
// pops and compares them whenever FRAME_VLD is seen.
module tb_seg_scan_decoder;

  localparam int unsigned StableCycles  = 4;
  localparam int unsigned TimeoutCycles = 64;

  typedef struct packed {
    logic [19:0] chars;
    logic [3:0]  dps;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  disp_en;
  logic [7:0]  segments;
  logic [19:0] chars;
  logic [3:0]  dps;
  logic        frame_vld;
  logic        stale;
  logic        err;

  frame_t exp_q[$];
  frame_t mon_e;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     err_cnt = 0;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .STABLE_CYCLES  (StableCycles),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .DISP_EN   (disp_en),
    .SEGMENTS  (segments),
    .CHARS     (chars),
    .DPS       (dps),
    .FRAME_VLD (frame_vld),
    .STALE     (stale),
    .ERR       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic frame_t mk(input logic [4:0] c3, input logic [4:0] c2,
                                input logic [4:0] c1, input logic [4:0] c0,
                                input logic [3:0] d);
    frame_t f;
    f.chars = {c3, c2, c1, c0};
    f.dps   = d;
    return f;
  endfunction

  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (frame_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: got chars %0h dps %0h, required no frame", chars, dps);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_chars", chars, mon_e.chars);
        check("frame_dps", dps, mon_e.dps);
      end
    end
  end

  task automatic drive(input logic [3:0] en, input logic [7:0] seg, input int n);
    disp_en  = en;
    segments = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [3:0][7:0] s, input bit glitch);
    logic [3:0] en;
    for (int i = 0; i < 4; i++) begin
      en = ~(4'b0001 << i);
      if (glitch) drive(en, 8'h00, 2);
      drive(en, s[i], 10);
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    frame_t blank;
    int     e0;
    blank    = mk(5'h12, 5'h12, 5'h12, 5'h12, 4'b0000);
    rst      = 1'b1;
    disp_en  = 4'hF;
    segments = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_chars", chars, blank.chars);
    check("reset_dps", dps, 0);
    check("reset_frame_vld", frame_vld, 0);
    check("reset_stale", stale, 0);
    check("reset_err", err, 0);

    // "COOL" twice
    exp_q.push_back(mk(5'h10, 5'h00, 5'h00, 5'h0C, 4'b0000));
    exp_q.push_back(mk(5'h10, 5'h00, 5'h00, 5'h0C, 4'b0000));
    scan({8'hE3, 8'h03, 8'h03, 8'h63}, 1'b0);
    scan({8'hE3, 8'h03, 8'h03, 8'h63}, 1'b0);
    wait_drain("cool_drain");

    // "CrAP" with 2-cycle 8'h00 glitches before every digit
    drive(4'hF, 8'hFF, 8);
    exp_q.push_back(mk(5'h13, 5'h0A, 5'h11, 5'h0C, 4'b0000));
    scan({8'h31, 8'h11, 8'hF5, 8'h63}, 1'b1);
    wait_drain("crap_drain");

    // two anodes low at once
    e0 = err_cnt;
    drive(4'b1100, 8'hFF, 6);
    drive(4'hF, 8'hFF, 12);
    check("err_pulses", err_cnt - e0, 1);

    // timeout with three digits captured, then the fourth completes the frame
    exp_q.push_back(mk(5'h04, 5'h03, 5'h02, 5'h01, 4'b0000));
    drive(4'b1110, 8'h9F, 10);
    drive(4'b1101, 8'h25, 10);
    drive(4'b1011, 8'h0D, 10);
    drive(4'hF, 8'hFF, 40);
    check("stale_early", stale, 0);
    drive(4'hF, 8'hFF, 30);
    check("stale_set", stale, 1);
    drive(4'b0111, 8'h99, 10);
    check("stale_cleared", stale, 0);
    wait_drain("timeout_drain");

    // reset mid-frame drops the partial slots
    drive(4'b1110, 8'h9F, 10);
    drive(4'b1101, 8'h25, 10);
    rst = 1'b1;
    drive(4'hF, 8'hFF, 2);
    rst = 1'b0;
    check("midreset_chars", chars, blank.chars);
    check("midreset_dps", dps, 0);
    drive(4'b1011, 8'h0D, 10);
    drive(4'b0111, 8'h99, 10);
    drive(4'hF, 8'hFF, 10);
    check("after_reset_chars", chars, blank.chars);

    // decimal point on digit 2, unknown pattern on digit 1
    rst = 1'b1;
    drive(4'hF, 8'hFF, 2);
    rst = 1'b0;
    exp_q.push_back(mk(5'h12, 5'h00, 5'h1F, 5'h12, 4'b0100));
    scan({8'hFF, 8'h02, 8'hAB, 8'hFF}, 1'b0);
    wait_drain("dp_drain");

    drive(4'hF, 8'hFF, 5);
    check("err_total", err_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
